// File: rtl/mpu_user_fifo.sv
// -----------------------------------------------------------------------------
// mpu_user_fifo
//
// Purpose:
//   Captures MPU user events (rising edge of user_irq plus a 64-bit payload)
//   into a show-ahead FIFO on sys_clk. The head entry is presented to the CSR
//   side, which pops it. Raises a level irq at a fill threshold and counts
//   events dropped on overflow.
//
// Ports:
//   sys_clk    in   1             clock
//   sys_rst    in   1             asynchronous, active-low reset
//   user_irq   in   1             event strobe; each rising edge is one event
//   user_data  in   64            payload, sampled in the cycle of the edge
//   rd_pop     in   1             consume head entry
//   flush      in   1             discard all entries (synchronous)
//   ovf_clr    in   1             clear ovf and drop_cnt
//   rd_data    out  64            head entry, valid when rd_valid=1
//   rd_valid   out  1             FIFO non-empty
//   level      out  DEPTH_LOG2+1  entry count
//   full       out  1             level == 2**DEPTH_LOG2
//   ovf        out  1             sticky: an event was dropped
//   drop_cnt   out  16            dropped events, saturating
//   irq        out  1             registered, level >= IRQ_THRESH
//
// Read handshake: rd_valid=1 means rd_data holds the head entry. An entry is
// consumed on a clock edge where rd_valid=1 and rd_pop=1; rd_pop while
// rd_valid=0 is ignored. The producer side has no back-pressure: an event
// that finds no free slot is dropped and counted.
// -----------------------------------------------------------------------------
module mpu_user_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  user_irq,
    input  logic [63:0]           user_data,
    input  logic                  rd_pop,
    input  logic                  flush,
    input  logic                  ovf_clr,
    output logic [63:0]           rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  ovf,
    output logic [15:0]           drop_cnt,
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] level_nxt;
    logic [63:0]   head_nxt;
    logic          user_irq_q;
    logic          ev;
    logic          empty;
    logic          pop_en;
    logic          wr_en;
    logic          drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign rd_valid = ~empty;
    assign level    = wr_ptr - rd_ptr;

    // MPU side is half rate, so user_irq can be held for several cycles.
    assign ev = user_irq & ~user_irq_q;

    always_comb begin
        pop_en     = 1'b0;
        wr_en      = 1'b0;
        drop       = 1'b0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = '0;
        head_nxt   = '0;

        // A pop frees its slot first, so a push into a full FIFO succeeds
        // when accompanied by a valid pop. flush overrides everything.
        pop_en = rd_pop & ~empty & ~flush;
        wr_en  = ev & ~flush & (~full | pop_en);
        drop   = ev & ~flush & full & ~pop_en;

        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, wr_en};
            rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, pop_en};
        end
        level_nxt = wr_ptr_nxt - rd_ptr_nxt;

        // The next head is the word being written this cycle when the read
        // pointer lands on the current write slot; otherwise it is in memory.
        if (wr_en && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = user_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt[PW-2:0]];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr[PW-2:0]] <= user_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            user_irq_q <= 1'b0;
            rd_data    <= '0;
            irq        <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            user_irq_q <= user_irq;
            irq        <= (level_nxt >= PW'(IRQ_THRESH));
            // rd_data is only meaningful while non-empty; hold it otherwise.
            if (wr_ptr_nxt != rd_ptr_nxt) begin
                rd_data <= head_nxt;
            end
        end
    end

    // A drop in the same cycle as ovf_clr wins and restarts the count at 1.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mpu_user_fifo.sv
// -----------------------------------------------------------------------------
// tb_mpu_user_fifo
//
// Directed bench for mpu_user_fifo (DEPTH_LOG2=4, IRQ_THRESH=1). Inputs are
// driven 1 ns after the rising edge and outputs are checked at that point,
// so every check sees the state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_mpu_user_fifo;

    logic        sys_clk;
    logic        sys_rst;
    logic        user_irq;
    logic [63:0] user_data;
    logic        rd_pop;
    logic        flush;
    logic        ovf_clr;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic [4:0]  level;
    logic        full;
    logic        ovf;
    logic [15:0] drop_cnt;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    mpu_user_fifo #(.DEPTH_LOG2(4), .IRQ_THRESH(1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .user_irq  (user_irq),
        .user_data (user_data),
        .rd_pop    (rd_pop),
        .flush     (flush),
        .ovf_clr   (ovf_clr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .level     (level),
        .full      (full),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .irq       (irq)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- check + driver tasks ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One event: rising edge with payload, then back low for one cycle.
    task automatic push_event(input logic [63:0] d);
        user_irq  = 1'b1;
        user_data = d;
        tick();
        user_irq  = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_data"},  rd_data,  64'd0);
        check_eq({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check_eq({tag, "_level"},    64'(level),    64'd0);
        check_eq({tag, "_full"},     64'(full),     64'd0);
        check_eq({tag, "_ovf"},      64'(ovf),      64'd0);
        check_eq({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        check_eq({tag, "_irq"},      64'(irq),      64'd0);
    endtask

    // Pop everything in exp_q, comparing the head before each pop.
    task automatic drain_and_check(input string tag);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check_eq({tag, "_head"}, rd_data, e);
            pop_one();
        end
        check_eq({tag, "_empty"}, 64'(rd_valid), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sys_rst   = 1'b0;
        user_irq  = 1'b0;
        user_data = '0;
        rd_pop    = 1'b0;
        flush     = 1'b0;
        ovf_clr   = 1'b0;
        #23;
        check_all_zero("reset");
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        tick();
        tick();
        check_all_zero("idle");

        // 1: held level gives a single event, visible one edge later.
        user_irq  = 1'b1;
        user_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        check_eq("t1_level", 64'(level), 64'd1);
        check_eq("t1_data",  rd_data, 64'hDEAD_BEEF_0000_0001);
        check_eq("t1_valid", 64'(rd_valid), 64'd1);
        check_eq("t1_irq",   64'(irq), 64'd1);
        tick(); tick(); tick();
        check_eq("t1_hold_level", 64'(level), 64'd1);
        user_irq = 1'b0;
        tick();
        pop_one();
        check_eq("t1_pop_level", 64'(level), 64'd0);
        check_eq("t1_pop_irq",   64'(irq), 64'd0);

        // 2: fill, overflow by one, drain in order.
        for (int i = 0; i < 16; i++) begin
            push_event(64'(i));
            exp_q.push_back(64'(i));
        end
        check_eq("t2_full",  64'(full), 64'd1);
        check_eq("t2_level", 64'(level), 64'd16);
        check_eq("t2_pre_ovf", 64'(ovf), 64'd0);
        push_event(64'h99);
        check_eq("t2_ovf",      64'(ovf), 64'd1);
        check_eq("t2_drop_cnt", 64'(drop_cnt), 64'd1);
        check_eq("t2_level_after_drop", 64'(level), 64'd16);
        drain_and_check("t2");

        // 3: push + pop in the same cycle at full, empty and partial fill.
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("t3_clr_ovf", 64'(ovf), 64'd0);
        check_eq("t3_clr_cnt", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 16; i++) begin
            push_event(64'h100 + 64'(i));
            exp_q.push_back(64'h100 + 64'(i));
        end
        user_irq  = 1'b1;
        user_data = 64'hAAAA_5555_AAAA_5555;
        rd_pop    = 1'b1;
        tick();
        user_irq  = 1'b0;
        rd_pop    = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(64'hAAAA_5555_AAAA_5555);
        check_eq("t3_full_level", 64'(level), 64'd16);
        check_eq("t3_full_drop",  64'(drop_cnt), 64'd0);
        check_eq("t3_full_head",  rd_data, 64'h101);
        tick();
        drain_and_check("t3_full");

        // Empty: the pop is ignored, the pushed word becomes the head.
        user_irq  = 1'b1;
        user_data = 64'h0BAD_F00D;
        rd_pop    = 1'b1;
        tick();
        user_irq  = 1'b0;
        rd_pop    = 1'b0;
        check_eq("t3_empty_level", 64'(level), 64'd1);
        check_eq("t3_empty_head",  rd_data, 64'h0BAD_F00D);
        tick();
        pop_one();

        for (int i = 0; i < 5; i++) begin
            push_event(64'h200 + 64'(i));
        end
        user_irq  = 1'b1;
        user_data = 64'h2FF;
        rd_pop    = 1'b1;
        tick();
        user_irq  = 1'b0;
        rd_pop    = 1'b0;
        check_eq("t3_mid_level", 64'(level), 64'd5);
        check_eq("t3_mid_head",  rd_data, 64'h201);
        tick();

        // 4: flush beats push and pop, drop counter untouched.
        do_flush();
        for (int i = 0; i < 7; i++) begin
            push_event(64'h300 + 64'(i));
        end
        check_eq("t4_level7", 64'(level), 64'd7);
        flush     = 1'b1;
        user_irq  = 1'b1;
        user_data = 64'h3FF;
        rd_pop    = 1'b1;
        tick();
        flush    = 1'b0;
        user_irq = 1'b0;
        rd_pop   = 1'b0;
        check_eq("t4_level", 64'(level), 64'd0);
        check_eq("t4_valid", 64'(rd_valid), 64'd0);
        check_eq("t4_irq",   64'(irq), 64'd0);
        check_eq("t4_full",  64'(full), 64'd0);
        check_eq("t4_drop",  64'(drop_cnt), 64'd0);
        tick();
        pop_one();
        check_eq("t4_underflow_level", 64'(level), 64'd0);

        // 5: saturate drop_cnt, then drop together with ovf_clr.
        for (int i = 0; i < 16; i++) begin
            push_event(64'h400 + 64'(i));
        end
        for (int i = 0; i < 65535; i++) begin
            push_event(64'h5);
        end
        check_eq("t5_cnt_65535", 64'(drop_cnt), 64'hFFFF);
        push_event(64'h5);
        push_event(64'h5);
        check_eq("t5_cnt_sat", 64'(drop_cnt), 64'hFFFF);
        check_eq("t5_ovf",     64'(ovf), 64'd1);
        user_irq = 1'b1;
        ovf_clr  = 1'b1;
        tick();
        user_irq = 1'b0;
        ovf_clr  = 1'b0;
        check_eq("t5_clr_drop_ovf", 64'(ovf), 64'd1);
        check_eq("t5_clr_drop_cnt", 64'(drop_cnt), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("t5_clr_cnt", 64'(drop_cnt), 64'd0);

        // 6: asynchronous reset mid-stream, release with user_irq high.
        do_flush();
        for (int i = 0; i < 9; i++) begin
            push_event(64'h600 + 64'(i));
        end
        check_eq("t6_level9", 64'(level), 64'd9);
        #2;
        sys_rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        user_irq  = 1'b1;
        user_data = 64'h6666_7777;
        tick();
        tick();
        check_eq("t6_in_reset_level", 64'(level), 64'd0);
        #2;
        sys_rst = 1'b1;
        tick();
        check_eq("t6_release_level", 64'(level), 64'd1);
        check_eq("t6_release_data",  rd_data, 64'h6666_7777);
        tick();
        tick();
        check_eq("t6_single_event", 64'(level), 64'd1);
        user_irq = 1'b0;
        tick();

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
